// File: rtl/prbs8_checker.sv
// prbs8_checker
// Self-synchronising checker for the 8-bit Galois LFSR pattern generator.
// It hunts for a non-zero seed word, confirms LOCK_COUNT consecutive
// predicted words, then flywheels the prediction while locked. Mismatches
// in lock are flagged and counted. Lock is dropped when LOSS_THRESH
// mismatches land inside one LOSS_WINDOW-sample window.
//
// Ports
//   clock        rising-edge clock, sole clock domain
//   reset        synchronous active-high reset, highest priority
//   enable       data_in carries a valid sample this cycle
//   data_in      8-bit word from the generator
//   clear_count  synchronous clear of error_count (wins over an increment)
//   locked       registered, high while in LOCKED
//   error        registered one-cycle pulse per mismatch seen in LOCKED
//   error_count  registered 16-bit saturating mismatch count
//   state        registered FSM state: HUNT=00, SYNC=01, LOCKED=10
module prbs8_checker #(
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_THRESH = 4,
  parameter int LOSS_WINDOW = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  data_in,
  input  logic        clear_count,
  output logic        locked,
  output logic        error,
  output logic [15:0] error_count,
  output logic [1:0]  state
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WINDOW - 1);
  localparam logic [LW-1:0] MISS_LIMIT = LW'(LOSS_THRESH);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t          state_q;
  logic [7:0]      expected;
  logic [MW-1:0]   match_cnt;
  logic [WW-1:0]   win_cnt;
  logic [LW-1:0]   miss_cnt;

  logic            miss_hit;
  logic            win_wrap;
  logic [LW-1:0]   miss_new;
  logic            lose;

  // One generator step: feedback from bit 7 into taps 2, 3 and 4.
  function automatic logic [7:0] step(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Loss-window bookkeeping for the current LOCKED sample. A mismatch on the
  // wrapping sample is the first miss of the next window.
  always_comb begin
    miss_hit = (data_in != expected);
    win_wrap = (win_cnt == WIN_LAST);
    if (win_wrap) begin
      miss_new = miss_hit ? LW'(1) : '0;
    end else begin
      miss_new = miss_hit ? miss_cnt + LW'(1) : miss_cnt;
    end
    lose = miss_hit && (miss_new >= MISS_LIMIT);
  end

  assign state = state_q;

  // Registered stage: FSM, prediction, counters and all outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      expected    <= 8'h00;
      match_cnt   <= '0;
      win_cnt     <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_count <= 16'h0000;
    end else begin
      error <= 1'b0;
      if (clear_count) begin
        error_count <= 16'h0000;
      end
      if (enable) begin
        case (state_q)
          HUNT: begin
            // The all-zero lock-up word can never seed the predictor.
            if (data_in != 8'h00) begin
              expected  <= step(data_in);
              match_cnt <= '0;
              state_q   <= SYNC;
            end
          end
          SYNC: begin
            if (data_in == expected) begin
              expected <= step(data_in);
              if (match_cnt == MATCH_LAST) begin
                match_cnt <= '0;
                win_cnt   <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b1;
                state_q   <= LOCKED;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else if (data_in != 8'h00) begin
              expected  <= step(data_in);
              match_cnt <= '0;
            end else begin
              match_cnt <= '0;
              state_q   <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction runs from itself, never from data_in.
            expected <= step(expected);
            if (miss_hit) begin
              error <= 1'b1;
              if (!clear_count) begin
                error_count <= sat_inc(error_count);
              end
            end
            if (lose) begin
              win_cnt  <= '0;
              miss_cnt <= '0;
              locked   <= 1'b0;
              state_q  <= HUNT;
            end else begin
              win_cnt  <= win_wrap ? '0 : win_cnt + WW'(1);
              miss_cnt <= miss_new;
            end
          end
          default: begin
            state_q <= HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
